// File: rtl/shfifo_arb_pkg.sv
// Shared types and default sizing for the shared-FIFO write arbiter.
// Default values mirror the module parameters of shfifo_wr_arb.
package shfifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int FIFO_ADDR_DEF = 4;
  localparam int FIFO_DEPTH    = 1 << FIFO_ADDR_DEF;
  localparam int ID_W          = $clog2(NUM_REQ_DEF);
  localparam int CNT_W         = 8;

endpackage

// File: rtl/shfifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: lowest set request strictly above the last
// grant, wrapping, found with a double-width masked priority encoder.
module rr_pick
  import shfifo_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_lastGnt,
  output logic [$clog2(NUM_REQ)-1:0] o_winner,
  output logic                       o_any
);

  localparam int GW = $clog2(NUM_REQ);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_masked;

  // The upper copy is never masked, so a wrap-around winner is always found there.
  always_comb begin
    w_dbl    = {i_req, i_req};
    w_masked = '0;
    o_winner = '0;
    for (int j = 0; j < 2*NUM_REQ; j++) begin
      w_masked[j] = w_dbl[j] && (j > int'(i_lastGnt));
    end
    for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
      if (w_masked[j]) begin
        o_winner = (j >= NUM_REQ) ? GW'(j - NUM_REQ) : GW'(j);
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/shfifo_wr_arb.sv
// Round-robin burst arbiter sharing one sync FIFO write port among requesters.
// Writes are registered and gated on FIFO occupancy including the in-flight write.
module shfifo_wr_arb
  import shfifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FIFO_ADDR = FIFO_ADDR_DEF,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_vld,
  input  logic [NUM_REQ*DATA_W-1:0]    req_dat,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_rdy,
  output logic                         fifo_wen,
  output logic [DATA_W-1:0]            fifo_wdat,
  input  logic [FIFO_ADDR:0]           fifo_wcnt,
  output logic                         grant_vld,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         burst_abort
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int SW = FIFO_ADDR + 2;

  state_t           r_state, w_stateNxt;
  logic [GW-1:0]    r_gid, w_gidNxt;
  logic [GW-1:0]    r_lastGnt, w_lastGntNxt;
  logic [GW-1:0]    w_winner;
  logic [CNT_W-1:0] r_beatCnt, w_beatNxt;
  logic [CNT_W-1:0] r_idleCnt, w_idleNxt;
  logic             r_gvld, w_gvldNxt;
  logic             r_abort, w_abortNxt;
  logic             r_wen;
  logic [DATA_W-1:0] r_wdat;
  logic             w_any;
  logic             w_space;
  logic             w_accept;
  logic [SW-1:0]    w_fill;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req     (req_vld),
    .i_lastGnt (r_lastGnt),
    .o_winner  (w_winner),
    .o_any     (w_any)
  );

  assign w_fill   = SW'(fifo_wcnt) + SW'(r_wen);
  assign w_space  = w_fill < SW'(1 << FIFO_ADDR);
  assign w_accept = !rst && (r_state == BURST) && req_vld[r_gid] && w_space;

  always_comb begin
    req_rdy = '0;
    if (!rst && (r_state == BURST)) begin
      req_rdy[r_gid] = w_space;
    end
  end

  always_comb begin
    w_stateNxt   = r_state;
    w_gidNxt     = r_gid;
    w_gvldNxt    = r_gvld;
    w_lastGntNxt = r_lastGnt;
    w_beatNxt    = r_beatCnt;
    w_idleNxt    = r_idleCnt;
    w_abortNxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_stateNxt = BURST;
          w_gidNxt   = w_winner;
          w_gvldNxt  = 1'b1;
          w_beatNxt  = '0;
          w_idleNxt  = '0;
        end
      end
      BURST: begin
        // An accepted beat always beats the watchdog in the same cycle.
        if (w_accept) begin
          w_beatNxt = r_beatCnt + 1'b1;
          w_idleNxt = '0;
          if (req_last[r_gid] || (w_beatNxt == CNT_W'(MAX_BURST))) begin
            w_stateNxt   = IDLE;
            w_gvldNxt    = 1'b0;
            w_lastGntNxt = r_gid;
          end
        end else begin
          w_idleNxt = r_idleCnt + 1'b1;
          if (w_idleNxt == CNT_W'(TIMEOUT)) begin
            w_stateNxt   = IDLE;
            w_gvldNxt    = 1'b0;
            w_lastGntNxt = r_gid;
            w_abortNxt   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gid     <= '0;
      r_gvld    <= 1'b0;
      r_lastGnt <= GW'(NUM_REQ - 1);
      r_beatCnt <= '0;
      r_idleCnt <= '0;
      r_abort   <= 1'b0;
      r_wen     <= 1'b0;
      r_wdat    <= '0;
    end else begin
      r_state   <= w_stateNxt;
      r_gid     <= w_gidNxt;
      r_gvld    <= w_gvldNxt;
      r_lastGnt <= w_lastGntNxt;
      r_beatCnt <= w_beatNxt;
      r_idleCnt <= w_idleNxt;
      r_abort   <= w_abortNxt;
      r_wen     <= w_accept;
      if (w_accept) begin
        r_wdat <= req_dat[r_gid*DATA_W +: DATA_W];
      end
    end
  end

  assign fifo_wen    = r_wen;
  assign fifo_wdat   = r_wdat;
  assign grant_vld   = r_gvld;
  assign grant_id    = r_gid;
  assign burst_abort = r_abort;

endmodule

// File: tb/tb_shfifo_wr_arb.sv
// Bench for shfifo_wr_arb: directed scenarios plus a randomized run checked
// against a transaction-level arbiter model and a simple FIFO occupancy model.
module tb_shfifo_wr_arb;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int FA    = 4;
  localparam int MAXB  = 8;
  localparam int TMO   = 15;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    vld;
  logic [N*DW-1:0] dat;
  logic [N-1:0]    last;
  logic [N-1:0]    rdy;
  logic            wen;
  logic [DW-1:0]   wdat;
  logic [FA:0]     wcnt;
  logic            gvld;
  logic [1:0]      gid;
  logic            abort;

  always #5 clk = ~clk;

  shfifo_wr_arb #(
    .NUM_REQ(N), .DATA_W(DW), .FIFO_ADDR(FA), .MAX_BURST(MAXB), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req_vld(vld), .req_dat(dat), .req_last(last),
    .req_rdy(rdy), .fifo_wen(wen), .fifo_wdat(wdat), .fifo_wcnt(wcnt),
    .grant_vld(gvld), .grant_id(gid), .burst_abort(abort)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who holds the grant, how many beats and idle cycles so far.
  bit            mBurst = 0;
  bit            mWen = 0;
  bit            mAbort = 0;
  int            mGid = 0;
  int            mLastG = N - 1;
  int            mBeats = 0;
  int            mIdle = 0;
  logic [DW-1:0] mWdat = '0;

  logic [N-1:0]  sRdy;
  logic [N-1:0]  eRdy;
  bit            autoFifo = 0;
  int            occ = 0;
  int            drainPct = 50;

  function automatic logic [N-1:0] modelRdy();
    int fill;
    fill = int'(wcnt) + (mWen ? 1 : 0);
    if (rst) return '0;
    if (mBurst && fill < DEPTH) return 4'(1) << mGid;
    return '0;
  endfunction

  task automatic modelStep();
    bit acc;
    int fill;
    if (rst) begin
      mBurst = 0; mWen = 0; mAbort = 0; mGid = 0; mLastG = N - 1;
      mBeats = 0; mIdle = 0; mWdat = '0;
      return;
    end
    fill   = int'(wcnt) + (mWen ? 1 : 0);
    acc    = mBurst && vld[mGid] && (fill < DEPTH);
    mAbort = 0;
    mWen   = acc;
    if (acc) mWdat = dat[mGid*DW +: DW];
    if (!mBurst) begin
      if (vld != '0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (mLastG + k) % N;
          if (vld[c]) begin
            mGid = c;
            break;
          end
        end
        mBurst = 1; mBeats = 0; mIdle = 0;
      end
    end else if (acc) begin
      mBeats++;
      mIdle = 0;
      if (last[mGid] || mBeats == MAXB) begin
        mBurst = 0; mLastG = mGid;
      end
    end else begin
      mIdle++;
      if (mIdle == TMO) begin
        mBurst = 0; mLastG = mGid; mAbort = 1;
      end
    end
  endtask

  // One clock: sample req_rdy mid-cycle, advance models, return just after the edge.
  task automatic tick();
    int pop;
    @(negedge clk);
    sRdy = rdy;
    eRdy = modelRdy();
    pop  = (autoFifo && occ > 0 && $urandom_range(0, 99) < drainPct) ? 1 : 0;
    if (autoFifo) occ = occ + (mWen ? 1 : 0) - pop;
    modelStep();
    @(posedge clk);
    #1;
    if (autoFifo) wcnt = 5'((occ > DEPTH) ? DEPTH : occ);
  endtask

  task automatic doReset();
    autoFifo = 0;
    rst = 1; vld = '0; last = '0; wcnt = '0; dat = '0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; vld = 4'b1111; last = 4'b1111; wcnt = '0;
    for (int i = 0; i < N; i++) dat[i*DW +: DW] = $urandom;
    tick();
    checks++; if (sRdy !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rdy: got %b expected 0000", sRdy); end
    checks++; if (wen !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen: got %b expected 0", wen); end
    checks++; if (wdat !== '0) begin errors++; $display("[TB] FAIL reset_wdat: got %h expected 0", wdat); end
    checks++; if (gvld !== 1'b0) begin errors++; $display("[TB] FAIL reset_gvld: got %b expected 0", gvld); end
    checks++; if (gid !== 2'd0) begin errors++; $display("[TB] FAIL reset_gid: got %0d expected 0", gid); end
    checks++; if (abort !== 1'b0) begin errors++; $display("[TB] FAIL reset_abort: got %b expected 0", abort); end
    rst = 0; vld = '0; last = '0;
    tick();
  endtask

  task automatic test_single_burst();
    logic [DW-1:0] beats [3];
    beats[0] = 32'hA0A0_0000; beats[1] = 32'hA1A1_1111; beats[2] = 32'hA2A2_2222;
    vld = 4'b0001; last = '0; dat = '0; wcnt = '0;
    tick();
    checks++; if (gvld !== 1'b1) begin errors++; $display("[TB] FAIL single_gvld: got %b expected 1", gvld); end
    checks++; if (gid !== 2'd0) begin errors++; $display("[TB] FAIL single_gid: got %0d expected 0", gid); end
    checks++; if (wen !== 1'b0) begin errors++; $display("[TB] FAIL single_wen_grant: got %b expected 0", wen); end
    for (int i = 0; i < 3; i++) begin
      dat[0 +: DW] = beats[i];
      last[0] = (i == 2);
      tick();
      checks++; if (sRdy !== 4'b0001) begin errors++; $display("[TB] FAIL single_rdy%0d: got %b expected 0001", i, sRdy); end
      checks++; if (wen !== 1'b1) begin errors++; $display("[TB] FAIL single_wen%0d: got %b expected 1", i, wen); end
      checks++; if (wdat !== beats[i]) begin errors++; $display("[TB] FAIL single_wdat%0d: got %h expected %h", i, wdat, beats[i]); end
    end
    checks++; if (gvld !== 1'b0) begin errors++; $display("[TB] FAIL single_release: got %b expected 0", gvld); end
    vld = '0; last = '0;
    tick();
    checks++; if (wen !== 1'b0) begin errors++; $display("[TB] FAIL single_wen_after: got %b expected 0", wen); end
    vld = 4'b0011;
    tick();
    checks++; if (gid !== 2'd1) begin errors++; $display("[TB] FAIL single_next_rr: got %0d expected 1", gid); end
  endtask

  task automatic test_round_robin();
    int cnt [N];
    int order [$];
    bit prevG;
    int gap;
    doReset();
    prevG = 0; gap = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    vld = 4'b1111;
    for (int cyc = 0; cyc < 40 && order.size() < 5; cyc++) begin
      for (int i = 0; i < N; i++) begin
        last[i] = (cnt[i] % 2 == 1);
        dat[i*DW +: DW] = $urandom;
      end
      tick();
      for (int i = 0; i < N; i++) if (sRdy[i] && vld[i]) cnt[i]++;
      if (!gvld) gap++;
      else if (!prevG) begin
        order.push_back(int'(gid));
        if (order.size() > 1) begin
          checks++; if (gap !== 1) begin errors++; $display("[TB] FAIL rr_gap%0d: got %0d expected 1", order.size(), gap); end
        end
        gap = 0;
      end
      prevG = gvld;
    end
    checks++; if (order.size() !== 5) begin errors++; $display("[TB] FAIL rr_grants: got %0d expected 5", order.size()); end
    for (int k = 0; k < order.size(); k++) begin
      checks++; if (order[k] !== k % N) begin errors++; $display("[TB] FAIL rr_order%0d: got %0d expected %0d", k, order[k], k % N); end
    end
  endtask

  task automatic test_max_burst();
    int c1, c2, wens;
    int order [$];
    int acc1 [$];
    bit prevG;
    doReset();
    c1 = 0; c2 = 0; wens = 0; prevG = 0;
    for (int cyc = 0; cyc < 80 && !(c1 == 12 && c2 == 1); cyc++) begin
      vld = '0; last = '0;
      vld[1] = (c1 < 12); last[1] = (c1 == 11);
      vld[2] = (c2 < 1);  last[2] = 1'b1;
      for (int i = 0; i < N; i++) dat[i*DW +: DW] = $urandom;
      tick();
      if (sRdy[1] && vld[1]) begin
        c1++;
        if (acc1.size() > 0) acc1[acc1.size()-1]++;
      end
      if (sRdy[2] && vld[2]) c2++;
      if (wen) wens++;
      if (gvld && !prevG) begin
        order.push_back(int'(gid));
        if (gid == 2'd1) acc1.push_back(0);
      end
      prevG = gvld;
    end
    vld = '0; last = '0;
    checks++; if (order.size() !== 3) begin errors++; $display("[TB] FAIL maxb_grants: got %0d expected 3", order.size()); end
    if (order.size() == 3) begin
      checks++; if (order[0] !== 1 || order[1] !== 2 || order[2] !== 1) begin errors++; $display("[TB] FAIL maxb_order: got %0d,%0d,%0d expected 1,2,1", order[0], order[1], order[2]); end
    end
    checks++; if (acc1.size() !== 2) begin errors++; $display("[TB] FAIL maxb_req1_grants: got %0d expected 2", acc1.size()); end
    if (acc1.size() == 2) begin
      checks++; if (acc1[0] !== MAXB) begin errors++; $display("[TB] FAIL maxb_first: got %0d expected %0d", acc1[0], MAXB); end
      checks++; if (acc1[1] !== 4) begin errors++; $display("[TB] FAIL maxb_rest: got %0d expected 4", acc1[1]); end
    end
    checks++; if (wens !== 13) begin errors++; $display("[TB] FAIL maxb_writes: got %0d expected 13", wens); end
  endtask

  task automatic test_full_stall();
    doReset();
    vld = 4'b0001; last = '0; wcnt = 5'd14;
    tick();
    dat[0 +: DW] = 32'hB000_0000;
    tick();
    checks++; if (sRdy !== 4'b0001) begin errors++; $display("[TB] FAIL full_rdy14: got %b expected 0001", sRdy); end
    checks++; if (wen !== 1'b1) begin errors++; $display("[TB] FAIL full_wen14: got %b expected 1", wen); end
    wcnt = 5'd15; dat[0 +: DW] = 32'hB111_1111;
    tick();
    checks++; if (sRdy !== 4'b0000) begin errors++; $display("[TB] FAIL full_rdy15_inflight: got %b expected 0000", sRdy); end
    checks++; if (wen !== 1'b0) begin errors++; $display("[TB] FAIL full_wen15_inflight: got %b expected 0", wen); end
    wcnt = 5'd14;
    tick();
    checks++; if (sRdy !== 4'b0001) begin errors++; $display("[TB] FAIL full_rdy14b: got %b expected 0001", sRdy); end
    checks++; if (wdat !== 32'hB111_1111 || wen !== 1'b1) begin errors++; $display("[TB] FAIL full_one_beat: got wen=%b wdat=%h expected wen=1 wdat=b1111111", wen, wdat); end
    wcnt = 5'd15;
    tick();
    checks++; if (sRdy !== 4'b0000 || wen !== 1'b0) begin errors++; $display("[TB] FAIL full_second_stall: got rdy=%b wen=%b expected 0000/0", sRdy, wen); end
    wcnt = 5'd16;
    tick();
    checks++; if (sRdy !== 4'b0000 || wen !== 1'b0) begin errors++; $display("[TB] FAIL full_at_depth: got rdy=%b wen=%b expected 0000/0", sRdy, wen); end
    wcnt = '0; last[0] = 1'b1; dat[0 +: DW] = 32'hB222_2222;
    tick();
    checks++; if (wen !== 1'b1 || wdat !== 32'hB222_2222 || gvld !== 1'b0) begin errors++; $display("[TB] FAIL full_drain: got wen=%b wdat=%h gvld=%b expected 1/b2222222/0", wen, wdat, gvld); end
    vld = '0; last = '0;
    tick();
  endtask

  task automatic test_timeout();
    int pulses;
    doReset();
    vld = 4'b1000;
    tick();
    checks++; if (gvld !== 1'b1 || gid !== 2'd3) begin errors++; $display("[TB] FAIL tmo_grant: got gvld=%b gid=%0d expected 1/3", gvld, gid); end
    vld = 4'b0001; pulses = 0;
    for (int k = 1; k <= TMO; k++) begin
      tick();
      if (abort) pulses++;
      if (k == TMO - 1) begin
        checks++; if (gvld !== 1'b1 || pulses !== 0) begin errors++; $display("[TB] FAIL tmo_early: got gvld=%b pulses=%0d expected 1/0", gvld, pulses); end
      end
    end
    checks++; if (abort !== 1'b1 || gvld !== 1'b0) begin errors++; $display("[TB] FAIL tmo_abort: got abort=%b gvld=%b expected 1/0", abort, gvld); end
    tick();
    checks++; if (abort !== 1'b0) begin errors++; $display("[TB] FAIL tmo_pulse_width: got %b expected 0", abort); end
    checks++; if (gvld !== 1'b1 || gid !== 2'd0) begin errors++; $display("[TB] FAIL tmo_next_grant: got gvld=%b gid=%0d expected 1/0", gvld, gid); end
    last[0] = 1'b1;
    tick();
    vld = '0; last = '0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    doReset();
    vld = 4'b0100;
    tick();
    checks++; if (gid !== 2'd2) begin errors++; $display("[TB] FAIL rstmid_grant: got %0d expected 2", gid); end
    dat[2*DW +: DW] = 32'hC0C0_C0C0; rst = 1;
    tick();
    checks++; if (sRdy !== 4'b0000) begin errors++; $display("[TB] FAIL rstmid_rdy: got %b expected 0000", sRdy); end
    checks++; if (wen !== 1'b0 || gvld !== 1'b0 || wdat !== '0) begin errors++; $display("[TB] FAIL rstmid_clear: got wen=%b gvld=%b wdat=%h expected 0/0/0", wen, gvld, wdat); end
    rst = 0; vld = 4'b0101;
    tick();
    checks++; if (gvld !== 1'b1 || gid !== 2'd0) begin errors++; $display("[TB] FAIL rstmid_priority: got gvld=%b gid=%0d expected 1/0", gvld, gid); end
  endtask

  task automatic test_random();
    int act;
    doReset();
    autoFifo = 1; occ = 0; wcnt = '0; act = 50;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc % 50 == 0) begin
        act      = ($urandom_range(0, 3) == 0) ? 4 : int'($urandom_range(30, 90));
        drainPct = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(20, 90));
      end
      for (int i = 0; i < N; i++) begin
        vld[i]  = ($urandom_range(0, 99) < act);
        last[i] = ($urandom_range(0, 3) == 0);
        dat[i*DW +: DW] = $urandom;
      end
      tick();
      checks++; if (sRdy !== eRdy) begin errors++; $display("[TB] FAIL rand_rdy@%0d: got %b expected %b", cyc, sRdy, eRdy); end
      checks++; if (wen !== mWen) begin errors++; $display("[TB] FAIL rand_wen@%0d: got %b expected %b", cyc, wen, mWen); end
      checks++; if (wdat !== mWdat) begin errors++; $display("[TB] FAIL rand_wdat@%0d: got %h expected %h", cyc, wdat, mWdat); end
      checks++; if (gvld !== mBurst) begin errors++; $display("[TB] FAIL rand_gvld@%0d: got %b expected %b", cyc, gvld, mBurst); end
      checks++; if (gid !== 2'(mGid)) begin errors++; $display("[TB] FAIL rand_gid@%0d: got %0d expected %0d", cyc, gid, mGid); end
      checks++; if (abort !== mAbort) begin errors++; $display("[TB] FAIL rand_abort@%0d: got %b expected %b", cyc, abort, mAbort); end
      checks++; if (wen === 1'b1 && occ >= DEPTH) begin errors++; $display("[TB] FAIL rand_overflow@%0d: got write with occupancy %0d expected below %0d", cyc, occ, DEPTH); end
    end
    autoFifo = 0; vld = '0; last = '0;
  endtask

  initial begin
    rst = 1; vld = '0; last = '0; dat = '0; wcnt = '0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_max_burst();
    test_full_stall();
    test_timeout();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
